// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: clock-enable pixel divider, line/frame counters
// and registered sync, visible-area and pixel-coordinate outputs.
module vga_sync_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0,
   parameter int CLK_DIV  = 2
) (
   input  logic       clk,
   input  logic       clr,
   output logic       hsync,
   output logic       vsync,
   output logic       vga_on,
   output logic [9:0] Pixel_X,
   output logic [8:0] Pixel_Y,
   output logic       pixel_en,
   output logic       frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   // 11-bit bounds so a 1024-wide raster does not wrap the comparisons
   localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
   localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic        SYNC_ON  = (SYNC_POL != 0);

   logic [3:0]  div_cnt_q, div_cnt_d;
   logic [9:0]  h_cnt_q, h_cnt_d;
   logic [9:0]  v_cnt_q, v_cnt_d;
   logic        tick;
   logic [10:0] h_ext, v_ext;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        vga_on_q, vga_on_d;
   logic [9:0]  pix_x_q, pix_x_d;
   logic [8:0]  pix_y_q, pix_y_d;
   logic        pixel_en_q;
   logic        frame_start_q, frame_start_d;

   always_comb begin
      tick      = (div_cnt_q == DIV_LAST);
      div_cnt_d = tick ? 4'd0 : div_cnt_q + 4'd1;
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      if (tick) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = 10'd0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
         end
      end

      // Output set describes the pixel the counters have just moved onto
      h_ext         = {1'b0, h_cnt_d};
      v_ext         = {1'b0, v_cnt_d};
      vga_on_d      = (h_ext < H_VIS) && (v_ext < V_VIS);
      hsync_d       = ((h_ext >= HS_BEG) && (h_ext < HS_END)) ? SYNC_ON : ~SYNC_ON;
      vsync_d       = ((v_ext >= VS_BEG) && (v_ext < VS_END)) ? SYNC_ON : ~SYNC_ON;
      pix_x_d       = vga_on_d ? h_cnt_d : 10'd0;
      pix_y_d       = vga_on_d ? v_cnt_d[8:0] : 9'd0;
      frame_start_d = tick && (h_cnt_d == 10'd0) && (v_cnt_d == 10'd0);
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         div_cnt_q     <= 4'd0;
         h_cnt_q       <= H_LAST;
         v_cnt_q       <= V_LAST;
         hsync_q       <= ~SYNC_ON;
         vsync_q       <= ~SYNC_ON;
         vga_on_q      <= 1'b0;
         pix_x_q       <= 10'd0;
         pix_y_q       <= 9'd0;
         pixel_en_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         pixel_en_q    <= tick;
         frame_start_q <= frame_start_d;
         if (tick) begin
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            vga_on_q <= vga_on_d;
            pix_x_q  <= pix_x_d;
            pix_y_q  <= pix_y_d;
         end
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign vga_on      = vga_on_q;
   assign Pixel_X     = pix_x_q;
   assign Pixel_Y     = pix_y_q;
   assign pixel_en    = pixel_en_q;
   assign frame_start = frame_start_q;

endmodule
